// File: rtl/aes_inv_cipher_ctrl.sv
// AES-128 inverse cipher sequencer: walks the shared state datapath through
// ARK / InvShiftRows / InvSubBytes / InvMixColumns with a 10..0 round counter.
//
// Ports:
//   clk, reset (async, active-low)
//   load            start request (honoured in IDLE or DONE only)
//   keyReady        expanded key schedule valid (checked in WAIT_KEY only)
//   loadState       one-cycle strobe: capture ciphertext into state register
//   operation[3:0]  one-hot: [0] ARK, [1] InvSubBytes, [2] InvShiftRows,
//                   [3] InvMixColumns
//   roundKeyIndex   round key select (the round counter)
//   busy            high outside IDLE and DONE
//   decipherComplete high while in DONE (sticky until next load)
module aes_inv_cipher_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       keyReady,
  output logic       loadState,
  output logic [3:0] operation,
  output logic [3:0] roundKeyIndex,
  output logic       busy,
  output logic       decipherComplete
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LOAD     = 4'd1,
    WAIT_KEY = 4'd2,
    ARK      = 4'd3,
    DEC      = 4'd4,
    ISR      = 4'd5,
    ISB      = 4'd6,
    ISB_HOLD = 4'd7,
    IMC      = 4'd8,
    DONE     = 4'd9
  } state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] round;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Round counter: loaded on the way into WAIT_KEY,
  // stepped down on the way out of DEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round <= 4'd0;
    end else if (state == LOAD) begin
      round <= LAST;
    end else if (state == DEC && round != 4'd0) begin
      round <= round - 4'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      IDLE:     state_nxt = load ? LOAD : IDLE;
      LOAD:     state_nxt = WAIT_KEY;
      WAIT_KEY: state_nxt = keyReady ? ARK : WAIT_KEY;
      ARK: begin
        if (round == 4'd0) begin
          state_nxt = DONE;
        end else if (round == LAST) begin
          state_nxt = DEC;
        end else begin
          state_nxt = IMC;
        end
      end
      IMC:      state_nxt = DEC;
      DEC:      state_nxt = ISR;
      ISR:      state_nxt = ISB;
      ISB:      state_nxt = ISB_HOLD;
      ISB_HOLD: state_nxt = ARK;
      DONE:     state_nxt = load ? LOAD : DONE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    loadState        = 1'b0;
    operation        = 4'b0000;
    busy             = 1'b1;
    decipherComplete = 1'b0;
    unique case (state)
      IDLE:     busy = 1'b0;
      LOAD:     loadState = 1'b1;
      ARK:      operation = 4'b0001;
      ISB:      operation = 4'b0010;
      ISB_HOLD: operation = 4'b0010;
      ISR:      operation = 4'b0100;
      IMC:      operation = 4'b1000;
      DONE: begin
        busy             = 1'b0;
        decipherComplete = 1'b1;
      end
      default: ;
    endcase
  end

  assign roundKeyIndex = round;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl with an AES datapath model
// driven by the operation strobes.
module tb_aes_inv_cipher_ctrl;

  logic       clk;
  logic       reset;
  logic       load;
  logic       keyReady;
  logic       loadState;
  logic [3:0] operation;
  logic [3:0] roundKeyIndex;
  logic       busy;
  logic       decipherComplete;

  aes_inv_cipher_ctrl #(.NR(10)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .keyReady(keyReady),
    .loadState(loadState),
    .operation(operation),
    .roundKeyIndex(roundKeyIndex),
    .busy(busy),
    .decipherComplete(decipherComplete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  int checks = 0;
  int failures = 0;

  logic [7:0]   sb [256];
  logic [7:0]   isb[256];
  logic [31:0]  w  [44];
  logic [127:0] rk [11];

  int t;
  int done_t;
  int ark_n;
  int n_ark, n_isr, n_isb, n_imc;
  int onehot_bad = 0;
  int imc_bad = 0;
  int prev_ark = -1;
  logic [3:0]   prev_op = 4'b0000;
  logic [127:0] st = '0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = isb[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    int c, r, src;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      c = i / 4;
      r = i % 4;
      src = (c - r + 4) % 4;
      o[127-8*i -: 8] = s[127-8*(4*src+r) -: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    int idx;
    if ($countones(operation) > 1) onehot_bad++;
    if (loadState) begin
      st = CT;
      ark_n = 0;
      n_ark = 0; n_isr = 0; n_isb = 0; n_imc = 0;
    end
    if (operation[3] && prev_op[0] && (prev_ark == 10 || prev_ark == 0)) imc_bad++;
    if (operation[0]) begin
      idx = 10 - ark_n;
      if (idx < 0) idx = 0;
      check("ark_rki", 128'(roundKeyIndex), 128'(idx));
      st = st ^ rk[idx];
      prev_ark = idx;
      ark_n++;
      n_ark++;
    end
    if (operation[1]) begin
      n_isb++;
      if (!prev_op[1]) st = inv_sub(st);
    end
    if (operation[2]) begin
      n_isr++;
      st = inv_shift(st);
    end
    if (operation[3]) begin
      n_imc++;
      st = inv_mix(st);
    end
    if (decipherComplete && done_t < 0) done_t = t;
    prev_op = operation;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
    observe();
  endtask

  task automatic start_run();
    t = 0;
    done_t = -1;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_to_done(input int limit);
    while (done_t < 0 && t < limit) step();
  endtask

  initial begin
    logic [7:0]  inv;
    logic [31:0] tmp;
    logic [7:0]  rc;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = affine(inv);
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    t = 0;
    done_t = -1;
    reset = 1'b0;
    load = 1'b0;
    keyReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_loadState", 128'(loadState), 128'(0));
    check("rst_operation", 128'(operation), 128'(0));
    check("rst_rki", 128'(roundKeyIndex), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(decipherComplete), 128'(0));
    reset = 1'b1;
    step();
    check("idle_busy", 128'(busy), 128'(0));

    // Nominal run
    start_run();
    check("r1_loadState_c1", 128'(loadState), 128'(1));
    check("r1_busy_c1", 128'(busy), 128'(1));
    step();
    check("r1_rki_c2", 128'(roundKeyIndex), 128'(10));
    check("r1_op_c2", 128'(operation), 128'(0));
    step();
    check("r1_ark10_c3", 128'(operation), 128'(4'b0001));
    run_to_done(100);
    check("r1_done_cycle", 128'(done_t), 128'(63));
    check("r1_plaintext", st, PT);
    check("r1_n_ark", 128'(n_ark), 128'(11));
    check("r1_n_isr", 128'(n_isr), 128'(10));
    check("r1_n_isb", 128'(n_isb), 128'(20));
    check("r1_n_imc", 128'(n_imc), 128'(9));
    check("r1_imc_after_edge_ark", 128'(imc_bad), 128'(0));
    check("r1_done_op", 128'(operation), 128'(0));
    check("r1_done_rki", 128'(roundKeyIndex), 128'(0));

    // Restart from DONE at cycle 70
    while (t < 70) step();
    check("r2_sticky_done", 128'(decipherComplete), 128'(1));
    done_t = -1;
    load = 1'b1;
    step();
    load = 1'b0;
    check("r2_loadState_c71", 128'(loadState), 128'(1));
    check("r2_done_c71", 128'(decipherComplete), 128'(0));
    run_to_done(200);
    check("r2_done_cycle", 128'(done_t), 128'(133));
    check("r2_plaintext", st, PT);

    // Key stall for 5 cycles, then a late keyReady drop
    keyReady = 1'b0;
    start_run();
    while (t < 7) step();
    check("stall_op_c7", 128'(operation), 128'(0));
    check("stall_rki_c7", 128'(roundKeyIndex), 128'(10));
    check("stall_busy_c7", 128'(busy), 128'(1));
    keyReady = 1'b1;
    step();
    check("stall_ark_c8", 128'(operation), 128'(4'b0001));
    step();
    keyReady = 1'b0;
    run_to_done(120);
    check("stall_done_cycle", 128'(done_t), 128'(68));
    check("stall_plaintext", st, PT);
    keyReady = 1'b1;

    // Load pulses while busy are ignored
    start_run();
    while (t < 10) step();
    load = 1'b1;
    step();
    load = 1'b0;
    while (t < 40) step();
    load = 1'b1;
    step();
    load = 1'b0;
    run_to_done(120);
    check("lwb_done_cycle", 128'(done_t), 128'(63));
    check("lwb_plaintext", st, PT);
    check("lwb_n_ark", 128'(n_ark), 128'(11));

    // Reset mid-run at cycle 20
    start_run();
    while (t < 20) step();
    check("mid_busy_c20", 128'(busy), 128'(1));
    reset = 1'b0;
    #1;
    check("mid_rst_outputs",
          128'({loadState, operation, busy, decipherComplete}), 128'(0));
    check("mid_rst_rki", 128'(roundKeyIndex), 128'(0));
    load = 1'b1;
    step();
    check("rst_beats_load", 128'(loadState), 128'(0));
    load = 1'b0;
    step();
    reset = 1'b1;
    repeat (3) step();
    check("post_rst_busy", 128'(busy), 128'(0));
    check("post_rst_rki", 128'(roundKeyIndex), 128'(0));
    check("post_rst_op", 128'(operation), 128'(0));
    check("post_rst_no_done", 128'(done_t), 128'(-1));

    check("onehot_audit", 128'(onehot_bad), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
